// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and baud divisor helper.
// Used by both the transmitter and the receiver so their bit periods match.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY_BIT,
        STOP_BIT
    } uart_state_t;

    // Truncating divide; the resulting small rate error is tolerated by the line.
    function automatic int unsigned bit_cycles(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake into the UART transmitter (valid/ready, one byte per transfer).
// The host drives data_in/valid; the transmitter drives ready.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input  ready);
    modport slave  (input  data_in, input  valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled, tick on the terminal count.
// Latency: tick asserts BIT_CYCLES cycles after clear; no backpressure (free-running when enabled).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 12_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned BIT_CYCLES = bit_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && !clear_i && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1/8O1 when UART_TX_PARITY_EN is defined), LSB first, registered tx.
// Latency: tx falls 1 cycle after handshake; ready is low for the whole frame and during reset.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned CLOCK_FREQ = 12_000_000,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      n_rst,
    uart_tx_if.slave  host,
    output logic      tx_o,
    output logic      busy_o
);

    if (PARITY_ODD > 1) begin : g_parity_odd_range
        $error("PARITY_ODD must be 0 (even) or 1 (odd)");
    end

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_q, tx_d;
    logic        hs;
    logic        tick;
    logic        clear;

    assign host.ready = n_rst && (state_q == IDLE);
    assign hs         = host.valid && host.ready;
    assign tx_o       = tx_q;
    assign busy_o     = (state_q != IDLE);

    uart_baud_gen #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_baud_gen (
        .clk     (clk),
        .n_rst   (n_rst),
        .en_i    (busy_o),
        .clear_i (clear),
        .tick_o  (tick)
    );

`ifdef UART_TX_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY_BIT;

    // The shift register is consumed as bits go out, so parity is captured up front.
    logic par_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            par_q <= 1'b0;
        end else if (hs) begin
            par_q <= ^host.data_in ^ PARITY_ODD[0];
        end
    end
`else
    localparam uart_state_t AFTER_DATA = STOP_BIT;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        clear   = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    shift_d = host.data_in;
                    idx_d   = 3'd0;
                    clear   = 1'b1;
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (tick) state_d = DATA_BITS;
            end
            DATA_BITS: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = AFTER_DATA;
                end
            end
            PARITY_BIT: begin
                if (tick) state_d = STOP_BIT;
            end
            STOP_BIT: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from the next state so tx can be a plain flop.
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= 8'd0;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter: accepts one byte over a valid/ready handshake and serialises it on `tx` as 8N1, LSB first, at `BAUD_RATE`. It is the transmit counterpart of the design's UART receiver. It sits between the host-side command/data path and the board's serial TX pin, and shares the receiver's baud parameters so both ends run at identical bit periods.

## Interface
- `BAUD_RATE`, 115_200: line rate in bits/s.
- `CLOCK_FREQ`, 12_000_000: `clk` frequency in Hz.
- `PARITY_ODD`, 0: parity sense; 0 = even, 1 = odd. Used only with `UART_TX_PARITY_EN`.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset; synchronous, active-low.
- `data_in`  in  8  byte to send; sampled only on handshake.
- `valid`  in  1  `data_in` is offered.
- `ready`  out  1  transmitter can accept a byte this cycle.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  a frame is in progress, i.e. state != IDLE.

## Operation
- Derived constant `BIT_CYCLES = CLOCK_FREQ / BAUD_RATE`. At the defaults this is 104.
- Bit counter width is `$clog2(BIT_CYCLES)`. Division truncates; the resulting rate error is accepted.
- State machine states: IDLE, START_BIT, DATA_BITS, PARITY_BIT (only with the macro), STOP_BIT.
- IDLE:
  - `tx=1`, `ready=1`.
  - On `valid & ready`, latch `data_in` into the shift register, clear the baud counter, clear the bit index, and go to START_BIT.
- START_BIT: `tx=0` for `BIT_CYCLES` cycles, then go to DATA_BITS.
- DATA_BITS:
  - `tx = shift[0]`.
  - Every `BIT_CYCLES` cycles, shift right and increment the 3-bit index.
  - After index 7 completes, go to PARITY_BIT if the macro is defined, otherwise to STOP_BIT.
- STOP_BIT: `tx=1` for `BIT_CYCLES` cycles, then return to IDLE.
- `ready` is 0 in every state except IDLE. `ready` is also 0 while `n_rst` is low.
- `valid` and `data_in` are ignored outside IDLE. Changing `data_in` mid-frame has no effect.
- `valid` may be held high continuously; one byte is accepted per IDLE visit.
- Reset (any cycle, including mid-frame):
  - Next cycle: state IDLE, `tx=1`, `busy=0`, shift register 0, counters 0.
  - The partial frame is abandoned with no further line activity.

## Timing
- Handshake in cycle T: `tx` falls at T+1; `busy` rises at T+1.
- Start bit occupies cycles T+1..T+104 at the defaults.
- Data bit i occupies cycles T+1+104·(i+1) through T+104·(i+2).
- Stop bit ends at T+1040. IDLE is entered at T+1041, where `ready=1`.
- With `valid` held, the next handshake is at T+1041 and the next start bit begins at T+1042. The minimum inter-frame gap is therefore 1 idle cycle.
- Frame length is 10·`BIT_CYCLES` cycles, or 11·`BIT_CYCLES` with parity.
- `tx` comes from a flop; it has no combinational path from inputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY_BIT state is inserted after bit 7 and lasts `BIT_CYCLES`.
  - `tx = ^data ^ PARITY_ODD`, computed from the latched byte.
- `UART_TX_PARITY_EN` undefined: no PARITY_BIT state and no parity logic; the frame is 8N1.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_state_t` (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT), shared with the receiver;
  - the function `bit_cycles(clock_freq, baud_rate)`.
- Sub-module `uart_baud_gen`:
  - counts 0..`BIT_CYCLES`-1 and pulses `tick` on the terminal count;
  - has a synchronous `clear` input, driven on handshake;
  - is parameterised on `CLOCK_FREQ` and `BAUD_RATE`.

## Test plan
- Reset: hold `n_rst=0` for 5 cycles, then release → `tx=1`, `ready=1`, `busy=0`. `tx` stays 1 for 2000 cycles with `valid=0`.
- Single byte 0xA5 at the defaults:
  - Sample `tx` at bit midpoints (T+52+104·k) → expect 0,1,0,1,0,0,1,0,1,1.
  - `ready` returns at T+1041.
- Back-to-back: hold `valid=1` with 0x00 then 0xFF → exactly one idle-high cycle between the first stop bit and the second start bit. Second-frame data bits are all 1.
- Mid-frame input change: accept 0x3C, change `data_in` to 0xFF at T+300 with `valid=1` → the transmitted frame is still 0x3C. The second byte is accepted only at T+1041.
- Reset mid-frame: pull `n_rst` low at T+500 for one cycle → next cycle `tx=1`, `busy=0`, `ready=1` after release. No stray low pulses follow.
- With `UART_TX_PARITY_EN`, `PARITY_ODD=0`:
  - Send 0x07 → parity bit 1; send 0x03 → parity bit 0.
  - Frame length is 1144 cycles.
